// File: rtl/onchip_ram_pipe.sv
// ---------------------------------------------------------------------------
// onchip_ram_pipe
//   Single-port on-chip RAM slave with byte enables and a fully pipelined
//   read path (no waitrequest, one request per cycle).
//
//   Parameters
//     DATA_WIDTH   word width in bits (multiple of 8)
//     ADDR_WIDTH   word address width, depth = 2**ADDR_WIDTH
//     READ_LATENCY 1 or 2 en-cycles from read accept to readdatavalid
//                  (2 adds an output register after the array read;
//                  any value other than 2 builds the 1-cycle path)
//     INIT_FILE    power-up image, handed to the FPGA configuration flow
//                  through the ram_init_file attribute on the array
//
//   Ports
//     clk, reset_n       clock, asynchronous active-low reset
//     address            word address (wraps naturally modulo depth)
//     byteenable         per-byte write enable
//     chipselect/read/write/writedata   slave request
//     clken              clock enable, low freezes all state
//     reset_req          reset pending, blocks accepts and freezes state
//     err_clr            clears parity_err
//     readdata           read data, valid while readdatavalid is high
//     readdatavalid      one pulse (in en-cycles) per accepted read
//     parity_err         sticky read parity error flag
//
//   Build option
//     ONCHIP_RAM_PARITY_EN  defined: one even-parity bit stored per byte
//                           and checked on every readdatavalid.
//                           undefined: parity_err tied 0, err_clr ignored.
//
//   Memory contents carry no reset and survive reset_n.
// ---------------------------------------------------------------------------
module onchip_ram_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "onchip_ram_pipe.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    err_clr,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    parity_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  logic en;
  logic wr_acc;
  logic rd_acc;

  assign en     = clken & ~reset_req;
  assign wr_acc = en & chipselect & write;
  assign rd_acc = en & chipselect & read;

  // -------------------------------------------------------------------------
  // Storage array: byte-masked write, registered read. The read samples the
  // pre-write word; a same-cycle write to the same address is merged in
  // after the array (see fwd_* below). A read one cycle after a write sees
  // the updated array directly.
  // -------------------------------------------------------------------------
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] raw_word_reg;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_acc && byteenable[b]) begin
        mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
    if (rd_acc) begin
      raw_word_reg <= mem[address];
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 control. Read and write share one address, so a write accepted
  // with a read always targets the read word: remember which bytes it wrote.
  // blank1_reg forces readdata to zero after reset without putting a reset
  // on the array output register.
  // -------------------------------------------------------------------------
  logic                  valid1_reg;
  logic                  blank1_reg;
  logic [NBYTES-1:0]     fwd_be_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid1_reg   <= 1'b0;
      blank1_reg   <= 1'b1;
      fwd_be_reg   <= '0;
      fwd_data_reg <= '0;
    end else if (en) begin
      valid1_reg <= rd_acc;
      if (rd_acc) begin
        blank1_reg   <= 1'b0;
        fwd_be_reg   <= wr_acc ? byteenable : '0;
        fwd_data_reg <= writedata;
      end
    end
  end

  logic [DATA_WIDTH-1:0] word1;

  always_comb begin
    word1 = '0;
    if (!blank1_reg) begin
      for (int b = 0; b < NBYTES; b++) begin
        word1[b*8 +: 8] = fwd_be_reg[b] ? fwd_data_reg[b*8 +: 8]
                                        : raw_word_reg[b*8 +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  valid2_reg;
      logic [DATA_WIDTH-1:0] data2_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          valid2_reg <= 1'b0;
          data2_reg  <= '0;
        end else if (en) begin
          valid2_reg <= valid1_reg;
          if (valid1_reg) begin
            data2_reg <= word1;
          end
        end
      end

      assign readdata      = data2_reg;
      assign readdatavalid = valid2_reg;
    end else begin : g_lat1
      assign readdata      = word1;
      assign readdatavalid = valid1_reg;
    end
  endgenerate

`ifdef ONCHIP_RAM_PARITY_EN
  // -------------------------------------------------------------------------
  // Parity: one even-parity bit per byte, stored alongside the data and
  // carried through the same pipeline. Forwarded bytes get fresh parity.
  // -------------------------------------------------------------------------
  logic [NBYTES-1:0] par_mem [DEPTH];
  logic [NBYTES-1:0] raw_par_reg;
  logic [NBYTES-1:0] wr_par;
  logic [NBYTES-1:0] par1;
  logic [NBYTES-1:0] par_out;
  logic [NBYTES-1:0] byte_bad;
  logic              cur_err;
  logic              err_reg;

  always_comb begin
    wr_par = '0;
    for (int b = 0; b < NBYTES; b++) begin
      wr_par[b] = ^writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_acc && byteenable[b]) begin
        par_mem[address][b] <= wr_par[b];
      end
    end
    if (rd_acc) begin
      raw_par_reg <= par_mem[address];
    end
  end

  always_comb begin
    par1 = '0;
    if (!blank1_reg) begin
      for (int b = 0; b < NBYTES; b++) begin
        par1[b] = fwd_be_reg[b] ? ^fwd_data_reg[b*8 +: 8] : raw_par_reg[b];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_par_lat2
    logic [NBYTES-1:0] par2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        par2_reg <= '0;
      end else if (en && valid1_reg) begin
        par2_reg <= par1;
      end
    end

    assign par_out = par2_reg;
  end else begin : g_par_lat1
    assign par_out = par1;
  end

  always_comb begin
    byte_bad = '0;
    for (int b = 0; b < NBYTES; b++) begin
      byte_bad[b] = (^readdata[b*8 +: 8]) != par_out[b];
    end
  end

  // The flag is visible in the same cycle as the failing readdatavalid and
  // is held afterwards; a new error beats err_clr.
  assign cur_err = readdatavalid & (|byte_bad);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if (en) begin
      err_reg <= (err_reg & ~err_clr) | cur_err;
    end
  end

  assign parity_err = err_reg | cur_err;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign parity_err     = 1'b0;
`endif

endmodule

// File: doc/onchip_ram_pipe.md
ONCHIP_RAM_PIPE -- requirements
Module: onchip_ram_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10: word address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1: cycles from read accept to readdatavalid; legal values 1 or 2.
REQ-004 Parameter INIT_FILE, default "onchip_ram_pipe.hex": memory initialisation image.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 address  in  ADDR_WIDTH  word address.
REQ-009 byteenable  in  DATA_WIDTH/8  per-byte write enable.
REQ-010 chipselect  in  1  slave select.
REQ-011 read  in  1  read request.
REQ-012 write  in  1  write request.
REQ-013 writedata  in  DATA_WIDTH  write data.
REQ-014 clken  in  1  clock enable; low freezes all state.
REQ-015 reset_req  in  1  reset-pending; high blocks accepts and freezes state like clken low.
REQ-016 err_clr  in  1  clears parity_err.
REQ-017 readdata  out  DATA_WIDTH  read data, valid when readdatavalid high.
REQ-018 readdatavalid  out  1  one-cycle pulse per accepted read.
REQ-019 parity_err  out  1  sticky read parity error flag.

Function
REQ-020 en = clken & ~reset_req; nothing is accepted, stored or advanced when en is low.
REQ-021 Write accepted when en & chipselect & write; only bytes with byteenable set SHALL be updated, in the same edge.
REQ-022 Read accepted when en & chipselect & read; no waitrequest, one request per cycle, fully pipelined.
REQ-023 readdatavalid SHALL pulse exactly READ_LATENCY en-cycles after accept; cycles with en low SHALL not count and SHALL hold readdata/readdatavalid.
REQ-024 READ_LATENCY=2 SHALL add one output register stage after the array read.
REQ-025 Read and write accepted in the same cycle at the same address SHALL return the merged new data (written bytes new, others old).
REQ-026 Read accepted in the cycle after a write to the same address SHALL return the post-write word (bypass, no stale data).
REQ-027 Addresses wrap modulo depth; no out-of-range behaviour exists.
REQ-028 err_clr and a new error in the same cycle: parity_err SHALL be 1 (set wins).

Reset
REQ-029 reset_n low SHALL clear readdata to 0, readdatavalid to 0, parity_err to 0 and all pipeline valid bits immediately.
REQ-030 Reads in flight at reset SHALL be discarded; no readdatavalid after reset_n deasserts.
REQ-031 Memory contents SHALL be retained across reset; INIT_FILE applies only at configuration.

Configuration
REQ-032 Macro ONCHIP_RAM_PARITY_EN: defined -> one even-parity bit stored per byte, computed on written bytes; on each readdatavalid, any byte mismatch SHALL set parity_err, cleared only by err_clr or reset.
REQ-033 Macro undefined -> no parity storage; parity_err SHALL be tied 0; err_clr ignored; port list unchanged.

Verification
REQ-034 Write 0xDEADBEEF to addr 5, byteenable 0xF, then read addr 5, READ_LATENCY=1 -> readdatavalid one cycle after accept, readdata 0xDEADBEEF.
REQ-035 addr 5 = 0xDEADBEEF, write 0x00001122 with byteenable 0x3, read same cycle -> readdata 0xDEAD1122.
REQ-036 READ_LATENCY=2, back-to-back reads of addr 0,1,2 (preloaded 0xA,0xB,0xC) -> three consecutive readdatavalid pulses starting 2 cycles after first accept, data 0xA,0xB,0xC.
REQ-037 Read accepted, clken low 3 cycles, clken high -> readdatavalid appears only after latency en-cycles elapse, data correct, no duplicate pulse.
REQ-038 Two reads in flight, reset_n pulsed low -> readdata 0, readdatavalid 0, no pulses after release; prior-written addr still reads back correctly.
REQ-039 ONCHIP_RAM_PARITY_EN defined, force one stored parity bit flipped at addr 7, read addr 7 -> parity_err 1 with readdatavalid and stays 1; err_clr pulse -> 0.
